img_buf_arbiter: RTL

Owns the single-port image buffer RAM and shares it between three users: the SPI-side writer (controller FSM), the BNN reader, and a clear sweep that zeroes the RAM. Enforces fill → locked-read → clear sequencing. Generates the buffer_full and buffer_empty flags that the controller FSM consumes. Sits between controller_fsm, the BNN core, and the RAM macro.

---
 rtl/img_buf_arbiter_if.sv | 36 +++
 rtl/img_buf_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/img_buf_arbiter_if.sv
// rtl/img_buf_arbiter_if.sv - image buffer arbiter bus: writer, reader, clear and RAM macro signals
interface img_buf_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              clear;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_err;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              buffer_full;
    logic              buffer_empty;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  clear, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        output wr_ready, wr_err, rd_gnt, rd_valid, rd_data, buffer_full, buffer_empty,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output clear, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        input  wr_ready, wr_err, rd_gnt, rd_valid, rd_data, buffer_full, buffer_empty,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/img_buf_arbiter.sv
// rtl/img_buf_arbiter.sv - shares the image RAM between writer, BNN reader and clear sweep
module img_buf_arbiter #(
    parameter int DEPTH  = 113,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    img_buf_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_FILL, S_FULL, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_err_q, rd_valid_q, rd_zero_q, full_q, empty_q;

    logic wr_in_range, rd_in_range, wr_fire, wr_ok, rd_fire;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_X;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_X;

    // clear outranks everything: it blocks both the writer and the reader this cycle
    assign bus.wr_ready = (state_q == S_FILL) && !bus.clear;
    assign bus.rd_gnt   = (state_q == S_FULL) && bus.rd_req && !bus.clear;
    assign wr_fire      = bus.wr_req && bus.wr_ready;
    assign wr_ok        = wr_fire && wr_in_range;
    assign rd_fire      = bus.rd_gnt && rd_in_range;

    assign bus.wr_err       = wr_err_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = (rd_valid_q && !rd_zero_q) ? bus.mem_rdata : '0;
    assign bus.buffer_full  = full_q;
    assign bus.buffer_empty = empty_q;

    // next state: count counts accepted writes, sweep pointer walks 0..DEPTH-1
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (bus.clear) begin
            state_d = S_CLEAR;
            count_d = '0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (wr_ok) begin
                        count_d = count_q + 1'b1;
                        if (count_d == DEPTH_C) state_d = S_FULL;
                    end
                end
                S_FULL: ;
                S_CLEAR: begin
                    if (ptr_q == LAST_A) begin
                        state_d = S_FILL;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    // RAM port mux: sweep, then in-range write, then in-range read; idle drives zeros
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == S_CLEAR) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = ptr_q;
        end else if (wr_ok) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wdata = bus.wr_data;
        end else if (rd_fire) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.rd_addr;
        end
    end

    // state, counters and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            count_q    <= '0;
            ptr_q      <= '0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            wr_err_q   <= wr_fire && !wr_in_range;
            rd_valid_q <= bus.rd_gnt;
            rd_zero_q  <= !rd_in_range;
            full_q     <= (state_d == S_FULL);
            empty_q    <= (state_d == S_FILL) && (count_d == '0);
        end
    end
endmodule
